tcb_uart_peri: RTL and testbench
================================

// Module: tcb_uart_peri
// PURPOSE
//  UART peripheral (8N1, LSB first) behind a TCB subordinate port (common read/write channel).
//  TX path: TCB writes -> TX FIFO -> serializer -> uart_txd.
//  RX path: uart_rxd -> sampler -> RX FIFO -> TCB reads.
//  Runtime-programmable baud/sample dividers and FIFO-level interrupts; sits on the system bus as a slave peripheral.
// PARAMETERS
//  DW   8    UART data width (bits per frame)
//  FAW  5    FIFO address width; depth 2**FAW = 32 per direction
//  CW   16   baud/sample counter width
//  BDR_RST  433  reset value of TX/RX baud divider (cycles per bit minus 1)
//  SMP_RST  216  reset value of RX sample point (cycles from start edge minus 1)
// PORTS
//  clk       in   1     clock (from tcb.clk)
//  rst       in   1     reset, synchronous, active-high (from tcb.rst)
//  tcb       sub  tcb_if  TCB subordinate: vld, rdy, wen, adr, ben, wdt / rdt, sts (DBW=32)
//  uart_txd  out  1     serial transmit, idle high
//  uart_rxd  in   1     serial receive, asynchronous
//  irq_tx    out  1     TX FIFO load < TX IRQ level
//  irq_rx    out  1     RX FIFO load > RX IRQ level
// BEHAVIOUR
//  Clocking: one clock clk. rst is synchronous and active-high.
//  TCB handshake:
//   - rdy tied 1; a transfer occurs on vld&rdy.
//   - Read data and sts are valid DLY=1 cycle after the transfer.
//   - sts always 0. ben ignored (full 32-bit access).
//   - Unmapped addresses: reads return 0, writes are ignored.
//  Register map (adr[5:0]):
//   00 TX data     W: push wdt[DW-1:0]; push dropped if FIFO full. R: 0.
//   04 TX status   RO: TX FIFO load.
//   08 TX baud     RW: CW bits; bit period = val+1 cycles.
//   0C TX IRQ lvl  RW: FAW+1 bits; reset 0.
//   20 RX data     R: pop, rdt = zero-extended byte; empty FIFO -> rdt 0, no pop.
//   24 RX status   RO: RX FIFO load.
//   28 RX baud     RW: CW bits.
//   2C RX sample   RW: CW bits; first sample val+1 cycles after start edge.
//   30 RX IRQ lvl  RW: FAW+1 bits; reset 0.
//  TX serializer:
//   - States IDLE -> DATA (start bit 0, DW data bits LSB first, stop bit 1).
//   - Each bit lasts baud+1 cycles.
//   - When the FIFO is non-empty at the end of a stop bit, the next start bit follows immediately (no idle gap).
//   - Pop on frame start.
//  RX sampler:
//   - uart_rxd passes through a 2-FF synchronizer.
//   - IDLE: on falling edge, wait sample+1 cycles; if line is still 0, proceed, else return to IDLE.
//   - Then sample each data bit and the stop bit every baud+1 cycles.
//   - Stop=1: push byte. Stop=0: discard byte (framing error).
//   - RX FIFO full: byte dropped.
//  FIFO:
//   - Load is 0..2**FAW (FAW+1 bits). Pointers wrap.
//   - Simultaneous push and pop on a non-empty FIFO leaves load unchanged.
//  Interrupts: irq_tx = (tx_load < tx_lvl); irq_rx = (rx_load > rx_lvl). Both combinational from registers.
//  Reset values:
//   - uart_txd=1, irq_tx=0, irq_rx=0.
//   - FIFOs empty; serializer and sampler in IDLE.
//   - Baud/sample registers at *_RST; read data 0.
//  Reset mid-frame aborts the frame; uart_txd goes high next cycle.
// STRUCTURE
//  tcb_uart_pkg: register offset localparams; FSM state enums (IDLE/DATA).
//  Sub-module: tcb_uart_fifo (sync FIFO with load output), instantiated once for TX and once for RX.
//  The independent-channel variant (tcb_irw_uart) reuses the same core behind separate read/write TCB ports.
// TESTING (loopback uart_rxd=uart_txd)
//  Config write/readback:
//   - Write 08<=3, 28<=3, 2C<=1, 30<=12.
//   - Read back each register -> same values, sts 0.
//  Loopback string:
//   - Push "Hello, World!" (13 bytes) to 00.
//   - irq_rx rises within 13*40+100 cycles of start.
//   - 13 reads of 20 return the string in order.
//  Back-to-back TX: with baud=3, 2 queued bytes -> second start bit begins exactly 40 cycles after the first.
//  Empty/full:
//   - Read 20 with RX empty -> rdt 0, RX load stays 0.
//   - Write 33 bytes with TX stopped -> TX load saturates at 32.
//  Glitch/framing:
//   - 1-cycle low pulse on rxd -> no push.
//   - Frame with stop=0 -> no push.
//  IRQ levels: TX lvl 2, load 1 -> irq_tx=1; load 2 -> irq_tx=0.

Source files
------------

// File: rtl/tcb_uart_pkg.sv
// Shared definitions for the TCB UART peripheral: register offsets and FSM states.
package tcb_uart_pkg;

  // Register offsets, decoded from tcb_adr[5:0]
  localparam logic [5:0] AdrTxData = 6'h00;
  localparam logic [5:0] AdrTxStat = 6'h04;
  localparam logic [5:0] AdrTxBdr  = 6'h08;
  localparam logic [5:0] AdrTxLvl  = 6'h0C;
  localparam logic [5:0] AdrRxData = 6'h20;
  localparam logic [5:0] AdrRxStat = 6'h24;
  localparam logic [5:0] AdrRxBdr  = 6'h28;
  localparam logic [5:0] AdrRxSmp  = 6'h2C;
  localparam logic [5:0] AdrRxLvl  = 6'h30;

  typedef enum logic {StIdle, StData} uart_st_e;

endpackage

// File: rtl/tcb_uart_fifo.sv
// Synchronous FIFO with occupancy output.
// Ports: clk/rst (sync, active-high); push/wdata write side (dropped when full);
//        pop/rdata read side (ignored when empty, rdata is the head entry);
//        load = entries held (0..2**FAW); empty/full flags.
module tcb_uart_fifo #(
  parameter int unsigned DW  = 8,
  parameter int unsigned FAW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [FAW:0]  load,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0]  mem_q [2**FAW];
  logic [FAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FAW:0]   load_q, load_d;
  logic           push_ok, pop_ok;

  assign empty   = (load_q == '0);
  assign full    = (load_q == {1'b1, {FAW{1'b0}}});
  assign load    = load_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    load_d   = load_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FAW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + FAW'(1);
    case ({push_ok, pop_ok})
      2'b10:   load_d = load_q + (FAW+1)'(1);
      2'b01:   load_d = load_q - (FAW+1)'(1);
      default: load_d = load_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      load_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      load_q   <= load_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tcb_uart_peri.sv
// UART peripheral (8N1, LSB first) behind a TCB subordinate port.
// Ports: clk/rst (sync, active-high); tcb_* TCB subordinate (rdy tied 1, read data one
//        cycle after the transfer, sts always 0, ben ignored); uart_txd serial out (idle
//        high); uart_rxd asynchronous serial in; irq_tx / irq_rx FIFO-level interrupts.
module tcb_uart_peri
  import tcb_uart_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned FAW     = 5,
  parameter int unsigned CW      = 16,
  parameter int unsigned BDR_RST = 433,
  parameter int unsigned SMP_RST = 216
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tcb_vld,
  output logic        tcb_rdy,
  input  logic        tcb_wen,
  input  logic [31:0] tcb_adr,
  input  logic [3:0]  tcb_ben,
  input  logic [31:0] tcb_wdt,
  output logic [31:0] tcb_rdt,
  output logic        tcb_sts,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq_tx,
  output logic        irq_rx
);

  localparam int unsigned IW = $clog2(DW + 2);

  logic [CW-1:0] tx_bdr_q, tx_bdr_d, rx_bdr_q, rx_bdr_d, rx_smp_q, rx_smp_d;
  logic [FAW:0]  tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
  logic [31:0]   rdt_q, rdt_d;
  logic [5:0]    bus_adr;
  logic          unused_bus;

  logic          tx_push, tx_pop, tx_empty, tx_full, tx_start;
  logic [DW-1:0] tx_rdata;
  logic [FAW:0]  tx_load;
  uart_st_e      tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [IW-1:0] tx_idx_q, tx_idx_d;
  logic [DW+1:0] tx_sh_q, tx_sh_d;

  logic          rx_push, rx_pop, rx_empty, rx_full;
  logic [DW-1:0] rx_rdata;
  logic [FAW:0]  rx_load;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  uart_st_e      rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, rx_thr;
  logic [IW-1:0] rx_idx_q, rx_idx_d;
  logic [DW-1:0] rx_sh_q, rx_sh_d;

  assign bus_adr    = tcb_adr[5:0];
  assign unused_bus = ^{tcb_ben, tcb_adr[31:6], tcb_wdt[31:CW], tx_full, rx_full};
  assign tcb_rdy    = 1'b1;
  assign tcb_sts    = 1'b0;
  assign tcb_rdt    = rdt_q;
  assign irq_tx     = (tx_load < tx_lvl_q);
  assign irq_rx     = (rx_load > rx_lvl_q);
  assign uart_txd   = (tx_st_q == StData) ? tx_sh_q[0] : 1'b1;

  // Register file and bus decode
  always_comb begin
    tx_bdr_d = tx_bdr_q;
    tx_lvl_d = tx_lvl_q;
    rx_bdr_d = rx_bdr_q;
    rx_smp_d = rx_smp_q;
    rx_lvl_d = rx_lvl_q;
    rdt_d    = '0;
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    if (tcb_vld && tcb_wen) begin
      case (bus_adr)
        AdrTxData: tx_push  = 1'b1;
        AdrTxBdr:  tx_bdr_d = tcb_wdt[CW-1:0];
        AdrTxLvl:  tx_lvl_d = tcb_wdt[FAW:0];
        AdrRxBdr:  rx_bdr_d = tcb_wdt[CW-1:0];
        AdrRxSmp:  rx_smp_d = tcb_wdt[CW-1:0];
        AdrRxLvl:  rx_lvl_d = tcb_wdt[FAW:0];
        default:   ;
      endcase
    end else if (tcb_vld) begin
      case (bus_adr)
        AdrTxStat: rdt_d = 32'(tx_load);
        AdrTxBdr:  rdt_d = 32'(tx_bdr_q);
        AdrTxLvl:  rdt_d = 32'(tx_lvl_q);
        AdrRxData: begin
          if (!rx_empty) begin
            rdt_d  = 32'(rx_rdata);
            rx_pop = 1'b1;
          end
        end
        AdrRxStat: rdt_d = 32'(rx_load);
        AdrRxBdr:  rdt_d = 32'(rx_bdr_q);
        AdrRxSmp:  rdt_d = 32'(rx_smp_q);
        AdrRxLvl:  rdt_d = 32'(rx_lvl_q);
        default:   ;
      endcase
    end
  end

  // TX serializer: shift register holds {stop, data, start}, LSB drives the line.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_idx_d = tx_idx_q;
    tx_sh_d  = tx_sh_q;
    tx_start = 1'b0;
    unique case (tx_st_q)
      StIdle: tx_start = !tx_empty;
      StData: begin
        if (tx_cnt_q == tx_bdr_q) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IW'(DW + 1)) begin
            // Chain straight into the next frame when data is waiting
            tx_start = !tx_empty;
            tx_st_d  = StIdle;
          end else begin
            tx_idx_d = tx_idx_q + IW'(1);
            tx_sh_d  = {1'b1, tx_sh_q[DW+1:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_st_d = StIdle;
    endcase
    if (tx_start) begin
      tx_st_d  = StData;
      tx_cnt_d = '0;
      tx_idx_d = '0;
      tx_sh_d  = {1'b1, tx_rdata, 1'b0};
    end
  end
  assign tx_pop = tx_start;

  // RX sampler: idx 0 validates the start bit, 1..DW data, DW+1 stop.
  assign rx_thr = (rx_idx_q == '0) ? rx_smp_q : rx_bdr_q;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_idx_d = rx_idx_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    unique case (rx_st_q)
      StIdle: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_st_d  = StData;
          rx_cnt_d = '0;
          rx_idx_d = '0;
        end
      end
      StData: begin
        if (rx_cnt_q == rx_thr) begin
          rx_cnt_d = '0;
          if (rx_idx_q == '0) begin
            if (rx_s2_q) rx_st_d = StIdle;   // glitch, not a start bit
            else         rx_idx_d = IW'(1);
          end else if (rx_idx_q <= IW'(DW)) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[DW-1:1]};
            rx_idx_d = rx_idx_q + IW'(1);
          end else begin
            rx_push = rx_s2_q;                // low stop bit: framing error, drop
            rx_st_d = StIdle;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_bdr_q <= CW'(BDR_RST);
      tx_lvl_q <= '0;
      rx_bdr_q <= CW'(BDR_RST);
      rx_smp_q <= CW'(SMP_RST);
      rx_lvl_q <= '0;
      rdt_q    <= '0;
      tx_st_q  <= StIdle;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '1;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= StIdle;
      rx_cnt_q <= '0;
      rx_idx_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      tx_bdr_q <= tx_bdr_d;
      tx_lvl_q <= tx_lvl_d;
      rx_bdr_q <= rx_bdr_d;
      rx_smp_q <= rx_smp_d;
      rx_lvl_q <= rx_lvl_d;
      rdt_q    <= rdt_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      tx_sh_q  <= tx_sh_d;
      rx_s1_q  <= uart_rxd;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_idx_q <= rx_idx_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  tcb_uart_fifo #(.DW(DW), .FAW(FAW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (tcb_wdt[DW-1:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .load  (tx_load),
    .empty (tx_empty),
    .full  (tx_full)
  );

  tcb_uart_fifo #(.DW(DW), .FAW(FAW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_sh_q),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .load  (rx_load),
    .empty (rx_empty),
    .full  (rx_full)
  );

endmodule

// File: tb/tb_tcb_uart_peri.sv
// Directed bench for tcb_uart_peri: register access, loopback, timing, FIFO limits, IRQs.
module tb_tcb_uart_peri;

  logic        clk = 1'b0;
  logic        rst;
  logic        tcb_vld, tcb_wen, tcb_rdy, tcb_sts;
  logic [31:0] tcb_adr, tcb_wdt, tcb_rdt;
  logic [3:0]  tcb_ben;
  logic        uart_txd, uart_rxd, irq_tx, irq_rx;
  logic        loop, rxd_drv;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  assign uart_rxd = loop ? uart_txd : rxd_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcb_uart_peri dut (
    .clk      (clk),
    .rst      (rst),
    .tcb_vld  (tcb_vld),
    .tcb_rdy  (tcb_rdy),
    .tcb_wen  (tcb_wen),
    .tcb_adr  (tcb_adr),
    .tcb_ben  (tcb_ben),
    .tcb_wdt  (tcb_wdt),
    .tcb_rdt  (tcb_rdt),
    .tcb_sts  (tcb_sts),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd),
    .irq_tx   (irq_tx),
    .irq_rx   (irq_rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat);
    tcb_vld = 1'b1; tcb_wen = 1'b1; tcb_adr = adr; tcb_wdt = dat;
    step();
    tcb_vld = 1'b0; tcb_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] adr, output logic [31:0] dat, output logic sts);
    tcb_vld = 1'b1; tcb_wen = 1'b0; tcb_adr = adr;
    step();
    tcb_vld = 1'b0;
    dat = tcb_rdt;
    sts = tcb_sts;
  endtask

  task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    logic        s;
    bus_read(adr, d, s);
    check(tag, d, exp);
  endtask

  task automatic wait_txd(input logic v, input int limit, output logic ok);
    int n = 0;
    while (uart_txd !== v && n < limit) begin
      step();
      n++;
    end
    ok = (uart_txd === v);
  endtask

  // One bit at rx baud 3 (4 cycles)
  task automatic send_bit(input logic v);
    rxd_drv = v;
    repeat (4) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
    repeat (20) step();
  endtask

  initial begin
    logic [31:0] d;
    logic        s, ok;
    int unsigned t0, t1, c0;
    string       msg;
    msg = "Hello, World!";
    rst = 1'b1; tcb_vld = 1'b0; tcb_wen = 1'b0; tcb_adr = '0; tcb_wdt = '0;
    tcb_ben = 4'hF; loop = 1'b1; rxd_drv = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_irq_tx", 32'(irq_tx), 32'd0);
    check("rst_irq_rx", 32'(irq_rx), 32'd0);
    check("rst_rdt", tcb_rdt, 32'd0);
    read_check("rst_tx_bdr", 32'h08, 32'd433);
    read_check("rst_rx_bdr", 32'h28, 32'd433);
    read_check("rst_rx_smp", 32'h2C, 32'd216);
    read_check("rst_tx_load", 32'h04, 32'd0);

    // Config write / readback
    bus_write(32'h08, 32'd3);
    bus_write(32'h28, 32'd3);
    bus_write(32'h2C, 32'd1);
    bus_write(32'h30, 32'd12);
    bus_read(32'h08, d, s); check("cfg_tx_bdr", d, 32'd3); check("cfg_sts", 32'(s), 32'd0);
    read_check("cfg_rx_bdr", 32'h28, 32'd3);
    read_check("cfg_rx_smp", 32'h2C, 32'd1);
    bus_read(32'h30, d, s); check("cfg_rx_lvl", d, 32'd12); check("cfg_sts2", 32'(s), 32'd0);
    read_check("cfg_tx_lvl", 32'h0C, 32'd0);
    read_check("unmapped_rd", 32'h3C, 32'd0);

    // Back-to-back frames of 0xFF: only start bits fall
    bus_write(32'h00, 32'hFF);
    bus_write(32'h00, 32'hFF);
    wait_txd(1'b0, 50, ok);
    check("b2b_start0", 32'(ok), 32'd1);
    t0 = cyc;
    wait_txd(1'b1, 50, ok);
    wait_txd(1'b0, 100, ok);
    check("b2b_start1", 32'(ok), 32'd1);
    t1 = cyc;
    check("b2b_gap", t1 - t0, 32'd40);
    repeat (70) step();
    read_check("b2b_rx_load", 32'h24, 32'd2);
    read_check("b2b_rx0", 32'h20, 32'hFF);
    read_check("b2b_rx1", 32'h20, 32'hFF);

    // Empty RX read
    read_check("empty_rd", 32'h20, 32'd0);
    read_check("empty_load", 32'h24, 32'd0);

    // Loopback string
    c0 = cyc;
    for (int i = 0; i < 13; i++) bus_write(32'h00, 32'(msg[i]));
    while (irq_rx !== 1'b1 && (cyc - c0) < 620) step();
    check("str_irq_rx", 32'(irq_rx), 32'd1);
    for (int i = 0; i < 13; i++) read_check($sformatf("str_rx%0d", i), 32'h20, 32'(msg[i]));
    check("str_irq_rx_clr", 32'(irq_rx), 32'd0);
    read_check("str_rx_load", 32'h24, 32'd0);

    // Glitch / framing with driven rxd
    rxd_drv = 1'b1;
    loop = 1'b0;
    repeat (5) step();
    rxd_drv = 1'b0;
    step();
    rxd_drv = 1'b1;
    repeat (50) step();
    read_check("glitch_load", 32'h24, 32'd0);
    send_frame(8'h55, 1'b0);
    read_check("frame_err_load", 32'h24, 32'd0);
    send_frame(8'hA5, 1'b1);
    read_check("frame_ok_load", 32'h24, 32'd1);
    read_check("frame_ok_data", 32'h20, 32'hA5);

    // TX saturation with the serializer stuck on a long bit
    bus_write(32'h08, 32'hFFFF);
    bus_write(32'h00, 32'h00);
    step();
    for (int i = 0; i < 33; i++) bus_write(32'h00, 32'(i));
    read_check("sat_tx_load", 32'h04, 32'd32);
    check("sat_txd_low", 32'(uart_txd), 32'd0);

    // Reset mid-frame
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_txd", 32'(uart_txd), 32'd1);
    read_check("midrst_tx_load", 32'h04, 32'd0);
    read_check("midrst_tx_bdr", 32'h08, 32'd433);

    // TX IRQ level
    bus_write(32'h0C, 32'd2);
    bus_write(32'h00, 32'h11);
    step();
    read_check("irq_load0", 32'h04, 32'd0);
    bus_write(32'h00, 32'h22);
    check("irq_tx_load1", 32'(irq_tx), 32'd1);
    bus_write(32'h00, 32'h33);
    check("irq_tx_load2", 32'(irq_tx), 32'd0);
    read_check("irq_load2", 32'h04, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
